// File: rtl/nibble_logic_sequencer_if.sv
//==============================================================================
// Module      : nibble_logic_sequencer_if
// Description : Request/result bundle between a requester (register-file side)
//               and the nibble logic sequencer.
// Signals     : start, op, input1, input2, abort   requester -> sequencer
//               ready, busy, done, Output          sequencer -> requester
// Modports    : master (requester), slave (sequencer)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface nibble_logic_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] input1;
    logic [DATA_WIDTH-1:0] input2;
    logic                  abort;
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] Output;

    modport master (
        output start, op, input1, input2, abort,
        input  ready, busy, done, Output
    );

    modport slave (
        input  start, op, input1, input2, abort,
        output ready, busy, done, Output
    );
endinterface

`default_nettype wire

// File: rtl/nibble_logic_sequencer.sv
//==============================================================================
// Module      : nibble_logic_sequencer
// Description : Computes a DATA_WIDTH-bit bitwise AND/OR/XOR/NOR by time-sharing
//               one external SLICE_WIDTH-bit logic slice, one slice per clock,
//               least-significant slice first. Holds the operand and result
//               registers, the slice counter and the start/done handshake.
// Ports       : clk       rising-edge clock
//               rst_n     asynchronous active-low reset
//               bus       request/result interface (slave side)
//               slice_a   operand A slice presented to the shared slice
//               slice_b   operand B slice presented to the shared slice
//               slice_op  operation forwarded to the shared slice
//               slice_y   combinational slice result, captured the same cycle
// Parameters  : DATA_WIDTH must be an integer multiple of SLICE_WIDTH
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module nibble_logic_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int SLICE_WIDTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    nibble_logic_sequencer_if.slave     bus,
    output logic [SLICE_WIDTH-1:0]      slice_a,
    output logic [SLICE_WIDTH-1:0]      slice_b,
    output logic [1:0]                  slice_op,
    input  wire logic [SLICE_WIDTH-1:0] slice_y
);

    localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
    localparam int CNT_WIDTH  = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CNT_WIDTH-1:0] C_LAST = CNT_WIDTH'(NUM_SLICES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                                  r_state;
    logic [CNT_WIDTH-1:0]                    r_cnt;
    logic [1:0]                              r_op;
    logic [NUM_SLICES-1:0][SLICE_WIDTH-1:0]  r_a;
    logic [NUM_SLICES-1:0][SLICE_WIDTH-1:0]  r_b;
    logic [NUM_SLICES-1:0][SLICE_WIDTH-1:0]  r_res;
    logic [NUM_SLICES-1:0][SLICE_WIDTH-1:0]  r_out;
    logic                                    r_ready;
    logic                                    r_busy;
    logic                                    r_done;

    // Partial result with the top slice taken straight from the slice output,
    // so Output can be loaded on the same edge that captures the last slice.
    logic [NUM_SLICES-1:0][SLICE_WIDTH-1:0]  w_final;

    always_comb begin
        w_final                 = r_res;
        w_final[NUM_SLICES-1]   = slice_y;
    end

    // Slice operands are forced to zero outside RUN so the shared slice sees
    // no activity while this unit is idle. They stay combinational from the
    // counter because slice_y must be captured in the same cycle.
    always_comb begin
        slice_a  = '0;
        slice_b  = '0;
        slice_op = '0;
        if (r_state == S_RUN) begin
            slice_a  = r_a[r_cnt];
            slice_b  = r_b[r_cnt];
            slice_op = r_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_out   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.input1;
                        r_b     <= bus.input2;
                        r_op    <= bus.op;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Abort takes priority even over the final slice.
                    if (bus.abort) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_res[r_cnt] <= slice_y;
                        if (r_cnt == C_LAST) begin
                            r_out   <= w_final;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready  = r_ready;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.Output = r_out;

endmodule

`default_nettype wire
